// File: rtl/lock_sequencer.sv
// lock_sequencer: synchronized, debounced keypad lock FSM with failed-attempt lockout and alarm blink
module lock_sequencer #(
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = '0,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 65535,
  parameter int BLINK_BIT = 8
) (
  input logic clk,
  input logic rst_n,
  input logic btn_set,
  input logic btn_check,
  input logic [CODE_W-1:0] code,
  output logic unlocked,
  output logic alarm_led,
  output logic [2:0] state,
  output logic [3:0] fail_count,
  output logic lockout
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SET_AWAITING = 3'b001,
    OPENED = 3'b010,
    ALARM = 3'b011,
    INPUT_PASSWORD = 3'b100,
    LOCKOUT = 3'b101
  } state_t;
  state_t st;
  logic [1:0] b_s1, b_s2, evt;
  logic [CODE_W-1:0] c_s1, c_s2, password;
  logic [15:0] timer, blink;
  logic [3:0] nf;
  logic set_evt, check_evt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_s1 <= 2'b11;
      b_s2 <= 2'b11;
      c_s1 <= '0;
      c_s2 <= '0;
      blink <= '0;
    end else begin
      b_s1 <= {btn_check, btn_set};
      b_s2 <= b_s1;
      c_s1 <= code;
      c_s2 <= c_s1;
      blink <= blink + 16'd1;
    end
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic [DW-1:0] cnt;
    logic db, ev;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        db <= 1'b1;
        ev <= 1'b0;
      end else begin
        ev <= 1'b0;
        if (b_s2[b] == db) cnt <= '0;
        else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          db <= b_s2[b];
          ev <= ~b_s2[b];
        end else cnt <= cnt + 1'b1;
      end
    assign evt[b] = ev;
  end
  assign set_evt = evt[0];
  assign check_evt = evt[1];
  assign nf = (fail_count == 4'(MAX_FAILS)) ? fail_count : fail_count + 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      password <= DEFAULT_CODE;
      fail_count <= '0;
      timer <= '0;
    end else if (st == LOCKOUT) begin
      if (timer == '0) begin
        st <= IDLE;
        fail_count <= '0;
      end else timer <= timer - 16'd1;
    end else if (check_evt) begin
      if (st == IDLE) st <= INPUT_PASSWORD;
      else if (st == INPUT_PASSWORD) begin
        if (c_s2 == password) begin
          st <= OPENED;
          fail_count <= '0;
        end else begin
          fail_count <= nf;
          st <= (nf == 4'(MAX_FAILS)) ? LOCKOUT : ALARM;
          timer <= 16'(LOCKOUT_CYCLES - 1);
        end
      end else st <= IDLE;
    end else if (set_evt) begin
      if (st == OPENED) st <= SET_AWAITING;
      else if (st == SET_AWAITING) begin
        st <= IDLE;
        password <= c_s2;
      end else if (st == INPUT_PASSWORD) st <= IDLE;
    end
  assign state = st;
  assign unlocked = st == OPENED;
  assign lockout = st == LOCKOUT;
  assign alarm_led = (st == LOCKOUT) | ((st == ALARM) & blink[BLINK_BIT]);
endmodule
